// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one operation in flight (IDLE -> EXEC -> RESP),
// and the captured result is returned on the owner's response channel.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FW    = 12
) (
    input  logic             clk,
    input  logic             rstn,
    // port 0 command channel
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_f,
    // port 1 command channel
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_f,
    // response channels (result and error shared, qualified per port)
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_err,
    // ALU interface
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_f,
    input  logic [WIDTH-1:0] alu_y,
    // status
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_last_grant;   // port granted most recently
    logic             r_owner;        // port that issued the op in flight
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [FW-1:0]    r_f;
    logic [WIDTH-1:0] r_y;
    logic             r_err;

    logic             w_gnt_valid;
    logic             w_gnt_port;
    logic             w_accept;
    logic             w_rsp_done;
    logic             w_f_onehot;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [FW-1:0]    w_sel_f;

    // Round-robin grant: a lone requester wins; on a tie the port that was
    // not granted last time wins.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_port  = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_port  = ~r_last_grant;
        end else if (req0_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_port  = 1'b0;
        end else if (req1_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_port  = 1'b1;
        end
    end

    // Internal accept ignores rstn: while reset is asserted the flops are held
    // anyway, so only the visible ready outputs need to be forced low.
    assign w_accept   = (r_state == S_IDLE) && w_gnt_valid;
    assign req0_ready = rstn && w_accept && !w_gnt_port;
    assign req1_ready = rstn && w_accept &&  w_gnt_port;

    assign w_sel_a = w_gnt_port ? req1_a : req0_a;
    assign w_sel_b = w_gnt_port ? req1_b : req0_b;
    assign w_sel_f = w_gnt_port ? req1_f : req0_f;

    // Only the owner's ready completes the response; the other is ignored.
    assign w_rsp_done = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_f_onehot = (r_f != '0) && ((r_f & (r_f - FW'(1))) == '0);

    // Next-state logic for the single-operation pipeline.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_next = S_EXEC;
            S_EXEC:                  w_state_next = S_RESP;
            S_RESP:  if (w_rsp_done) w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch on accept and result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= 1'b1;   // so port 0 wins the first tie
            r_owner      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_f          <= '0;
            r_y          <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_f          <= w_sel_f;
                r_owner      <= w_gnt_port;
                r_last_grant <= w_gnt_port;
            end
            if (r_state == S_EXEC) begin
                r_y   <= alu_y;
                r_err <= !w_f_onehot;
            end
        end
    end

    // ALU drive: operands hold their last value, f is only presented in EXEC
    // so the ALU output is zero otherwise.
    assign alu_a = r_a;
    assign alu_b = r_b;
    assign alu_f = (r_state == S_EXEC) ? r_f : '0;

    assign rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == S_RESP) &&  r_owner;
    assign rsp_y      = r_y;
    assign rsp_err    = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule
